// File: rtl/uart_rx.sv
// uart_rx -- 16x-oversampling 8N1 serial receiver, LSB first.
//
// Synchronises the asynchronous RX line and watches it for a start edge.
// The start bit is confirmed at its midpoint; eight data bits and the stop
// bit are then sampled at their midpoints. A good frame updates DATA and
// pulses DATA_VALID. A low stop bit pulses FRAMING_ERROR and leaves DATA
// unchanged. There is no backpressure: the consumer must capture DATA in the
// DATA_VALID cycle.
//
// Ports:
//   CLK            in   system clock (single domain)
//   RESET          in   asynchronous, active-low reset
//   RX             in   serial input, asynchronous, idles high
//   DATA           out  last good received byte
//   DATA_VALID     out  one-cycle strobe, DATA updated this cycle
//   FRAMING_ERROR  out  one-cycle strobe, stop bit sampled low
//   BUSY           out  frame reception in progress
module uart_rx #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115200,
  parameter int DIVISOR = CLK_HZ / (BAUD * 16)
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       FRAMING_ERROR,
  output logic       BUSY
);

  localparam int              DIV_W    = $clog2(DIVISOR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_tick_cnt;
  logic             r_tick_seen;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  logic             w_tick;
  logic             w_mid;
  logic             w_clr;
  logic             w_shift;
  logic             w_load;
  logic             w_ferr;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rx_meta <= 1'b0;
      r_rx_s    <= 1'b0;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  // r_tick_seen marks the single cycle in which r_tick_cnt has just advanced.
  // Midpoints of start, data and stop bits are tick counts 8, 24, ..., 152,
  // i.e. every count whose low nibble is 8; the FSM state tells them apart.
  assign w_mid  = r_tick_seen && (r_tick_cnt[3:0] == 4'd8);

  assign BUSY   = (r_state == S_START) || (r_state == S_DATA) ||
                  (r_state == S_STOP);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_WAIT_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      S_WAIT_IDLE: begin
        if (r_rx_s) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (!r_rx_s) begin
          w_next = S_START;
          w_clr  = 1'b1;
        end
      end
      S_START: begin
        if (w_mid) w_next = r_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_mid) begin
          w_shift = 1'b1;
          if (r_bit_idx == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_mid) begin
          if (r_rx_s) begin
            w_load = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = S_WAIT_IDLE;
          end
        end
      end
      default: w_next = S_WAIT_IDLE;
    endcase
  end

  // Oversample divider and tick counter; both only run while a frame is in
  // progress and restart from zero on start-edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_div       <= '0;
      r_tick_cnt  <= '0;
      r_tick_seen <= 1'b0;
    end else if (w_clr) begin
      r_div       <= '0;
      r_tick_cnt  <= '0;
      r_tick_seen <= 1'b0;
    end else if (BUSY) begin
      r_div       <= w_tick ? '0 : r_div + DIV_W'(1);
      r_tick_seen <= w_tick;
      if (w_tick) r_tick_cnt <= r_tick_cnt + 8'd1;
    end else begin
      r_div       <= '0;
      r_tick_seen <= 1'b0;
    end
  end

  // Right shift: after eight samples the first (LSB) sample sits in bit 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else if (w_clr) begin
      r_bit_idx <= '0;
    end else if (w_shift) begin
      r_shift   <= {r_rx_s, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DATA          <= '0;
      DATA_VALID    <= 1'b0;
      FRAMING_ERROR <= 1'b0;
    end else begin
      DATA_VALID    <= w_load;
      FRAMING_ERROR <= w_ferr;
      if (w_load) DATA <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DIV = 27;
  localparam int BIT = 16 * DIV;
  localparam int LAT = 4 + 152 * DIV;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RX;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       FRAMING_ERROR;
  logic       BUSY;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       busy;
    logic       pbusy;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } exp_t;

  ev_t  dv_q[$];
  ev_t  fe_q[$];
  exp_t exp_dv[$];
  int   exp_fe[$];

  logic [7:0] last_good = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       prev_busy = 1'b0;
  int         both_viol = 0;
  int         chg_viol  = 0;

  uart_rx #(.CLK_HZ(50_000_000), .BAUD(115200)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX           (RX),
    .DATA         (DATA),
    .DATA_VALID   (DATA_VALID),
    .FRAMING_ERROR(FRAMING_ERROR),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event monitor: records strobes with their cycle, away from the edge.
  always @(negedge CLK) begin
    ev_t e;
    e.cyc   = cyc;
    e.d     = DATA;
    e.busy  = BUSY;
    e.pbusy = prev_busy;
    if (DATA_VALID === 1'b1) dv_q.push_back(e);
    if (FRAMING_ERROR === 1'b1) fe_q.push_back(e);
    if (DATA_VALID === 1'b1 && FRAMING_ERROR === 1'b1) both_viol++;
    if (RESET === 1'b1 && DATA !== prev_data && DATA_VALID !== 1'b1) chg_viol++;
    prev_data = DATA;
    prev_busy = BUSY;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  // Drives one 8N1 frame at BIT cycles per bit; optional reset window given
  // as cycle offsets within the frame (negative = no reset). Also records the
  // frame-level expectation.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int rst_on, input int rst_off);
    logic [9:0] bits;
    int         start;
    bits  = {stop, b, 1'b0};
    start = cyc;
    for (int k = 0; k < 10 * BIT; k++) begin
      if (k % BIT == 0) RX = bits[k / BIT];
      if (k == rst_on)  RESET = 1'b0;
      if (k == rst_off) RESET = 1'b1;
      if (k == 2) chk("busy_before_rise", BUSY, 1'b0);
      if (k == 3) chk("busy_rise", BUSY, 1'b1);
      sync();
    end
    RX = 1'b1;
    if (rst_on >= 0) begin
      last_good = 8'h00;
    end else if (stop) begin
      exp_t x;
      x.cyc = start + LAT;
      x.d   = b;
      exp_dv.push_back(x);
      last_good = b;
    end else begin
      exp_fe.push_back(start + LAT);
    end
  endtask

  task automatic checkpoint(input string tag);
    int n;
    chk({tag, "_n_valid"}, dv_q.size(), exp_dv.size());
    chk({tag, "_n_ferr"},  fe_q.size(), exp_fe.size());
    n = (dv_q.size() < exp_dv.size()) ? dv_q.size() : exp_dv.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid_cyc"},   dv_q[i].cyc,   exp_dv[i].cyc);
      chk({tag, "_valid_data"},  dv_q[i].d,     exp_dv[i].d);
      chk({tag, "_busy_fall"},   dv_q[i].busy,  1'b0);
      chk({tag, "_busy_before"}, dv_q[i].pbusy, 1'b1);
    end
    n = (fe_q.size() < exp_fe.size()) ? fe_q.size() : exp_fe.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_ferr_cyc"},  fe_q[i].cyc,  exp_fe[i]);
      chk({tag, "_ferr_busy"}, fe_q[i].busy, 1'b0);
    end
    chk({tag, "_data_hold"}, DATA, last_good);
    dv_q.delete();
    fe_q.delete();
    exp_dv.delete();
    exp_fe.delete();
  endtask

  initial begin
    // Reset with RX low.
    RESET = 1'b0;
    RX    = 1'b0;
    idle(5);
    chk("rst_data",  DATA, 8'h00);
    chk("rst_valid", DATA_VALID, 1'b0);
    chk("rst_ferr",  FRAMING_ERROR, 1'b0);
    chk("rst_busy",  BUSY, 1'b0);
    RESET = 1'b1;
    idle(50);
    chk("wait_idle_busy", BUSY, 1'b0);
    RX = 1'b1;
    idle(20);
    chk("idle_busy", BUSY, 1'b0);
    checkpoint("reset");

    // Single byte.
    send_frame(8'h41, 1'b1, -1, -1);
    idle(20);
    checkpoint("single");

    // Back-to-back burst "ABCDE", no idle gap.
    for (int i = 0; i < 5; i++) send_frame(8'h41 + 8'(i), 1'b1, -1, -1);
    idle(20);
    checkpoint("burst");

    // Start glitch of 100 cycles.
    begin
      RX = 1'b0;
      for (int k = 0; k < 300; k++) begin
        if (k == 100) RX = 1'b1;
        if (k == 3)   chk("glitch_busy_rise", BUSY, 1'b1);
        if (k == 219) chk("glitch_busy_hold", BUSY, 1'b1);
        if (k == 220) chk("glitch_busy_drop", BUSY, 1'b0);
        sync();
      end
    end
    checkpoint("glitch");

    // Framing error, line held low two more bit periods, then recovery.
    send_frame(8'h55, 1'b0, -1, -1);
    RX = 1'b0;
    idle(2 * BIT);
    RX = 1'b1;
    idle(50);
    checkpoint("ferr");
    send_frame(8'h45, 1'b1, -1, -1);
    idle(20);
    checkpoint("recover");

    // Reset during bit 3 of 0x3C, released during low bit 6.
    send_frame(8'h3C, 1'b1, 4 * BIT + 200, 7 * BIT + 200);
    idle(20);
    checkpoint("rst_mid");
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(20);
    checkpoint("after_rst");

    // Randomised frames with occasional bad stop bits and random gaps.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      logic       s;
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s, -1, -1);
      idle(s ? int'($urandom_range(0, 200)) : int'($urandom_range(10, 200)));
    end
    idle(20);
    checkpoint("random");

    chk("exclusive_strobes", both_viol, 0);
    chk("data_change_only_on_valid", chg_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the `uart_echo` path. Oversamples the asynchronous `RX` line at 16x the baud rate and deserialises 8N1 frames, LSB first. Presents each received byte with a one-cycle strobe to the downstream echo buffer/transmitter. Flags stop-bit violations and rejects start-bit glitches.

## Interface
- `CLK_HZ`, 50_000_000: `CLK` frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DIVISOR`, `CLK_HZ/(BAUD*16)` (integer truncation, 27 at defaults): `CLK` cycles per oversample tick. Must be ≥ 2.

- `CLK`  in  1  system clock. One clock domain.
- `RESET`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  serial input, asynchronous, idles high.
- `DATA`  out  8  last good received byte.
- `DATA_VALID`  out  1  one-cycle strobe: `DATA` updated this cycle.
- `FRAMING_ERROR`  out  1  one-cycle strobe: stop bit sampled low.
- `BUSY`  out  1  frame reception in progress.

## Operation
- **Synchroniser:** `RX` passes through two flops before use; call the output `rx_s`. Both flops reset to 0.
- **Tick generator:** counter `0..DIVISOR-1`, emits `tick` on terminal count. Cleared to 0 on entry to START.
- **Tick counter:** `tick_cnt`, 8 bits, counts ticks since START entry.
- **State machine, reset state WAIT_IDLE:**
  - **WAIT_IDLE:** go to IDLE when `rx_s`=1. Prevents a false start when reset releases mid-frame or during a break.
  - **IDLE:** `rx_s`=0 → START. Clears the tick generator and `tick_cnt`.
  - **START:** at tick 8 (mid start bit), `rx_s`=0 → DATA; `rx_s`=1 → IDLE (glitch, no output).
  - **DATA:** at ticks 24, 40, …, 136, shift `rx_s` into bit 0..7 of the shift register, LSB first. After bit 7 → STOP.
  - **STOP:** at tick 152 (mid stop bit):
    - `rx_s`=1: load `DATA` from the shift register, pulse `DATA_VALID`, → IDLE.
    - `rx_s`=0: pulse `FRAMING_ERROR`, leave `DATA` unchanged, → WAIT_IDLE.
- **BUSY** = 1 in START, DATA and STOP; 0 in IDLE and WAIT_IDLE.
- **No backpressure.** `DATA` holds until the next good frame. The consumer must capture on `DATA_VALID`. An uncaptured byte is overwritten silently.
- **Back-to-back frames:** the return to IDLE happens at mid stop bit, so the next start edge is detected immediately. This tolerates a receiver clock up to ~3% slower or faster than the line rate.

## Timing
- **Reset values:** `DATA`=0x00, `DATA_VALID`=0, `FRAMING_ERROR`=0, `BUSY`=0. Internal counters and the shift register are 0.
- **Reset asserted mid-frame:** all state aborts immediately and no strobe is emitted. The block re-enters WAIT_IDLE on release.
- **Input latency:** `RX` to `rx_s` is 2 `CLK` cycles.
- **Start detection:** let T be the cycle IDLE observes `rx_s`=0. START is entered at T+1.
  - Tick n occurs at T+1+n·DIVISOR.
  - The start sample is taken at tick 8.
- **Output strobes:** `DATA_VALID` or `FRAMING_ERROR` is high for exactly one cycle, the cycle after the tick-152 sample, i.e. T+2+152·DIVISOR. At defaults this is T+4106.
- **`DATA`** changes only in the same cycle that `DATA_VALID`=1.
- **Exclusivity:** `DATA_VALID` and `FRAMING_ERROR` are never high together.
- **`BUSY` timing:** rises at T+1; falls in the strobe cycle.
- **Glitch rejection:** a low pulse on `RX` shorter than about 8·DIVISOR cycles is rejected. At defaults that is < 216 cycles.

## Test plan
1. **Reset behaviour.**
   - Assert `RESET`=0 with `RX` held low → all outputs 0.
   - Release → the block stays in WAIT_IDLE with no `BUSY`.
   - Drive `RX`=1 → IDLE.
2. **Single byte.** Send 0x41 ('A') at 432 clk/bit → exactly one `DATA_VALID` pulse at T+2+152·27, with `DATA`=0x41 and `FRAMING_ERROR` never asserted.
3. **Back-to-back burst.** Send "ABCDE" with one stop bit each and no idle gap → five `DATA_VALID` pulses carrying 0x41, 0x42, 0x43, 0x44, 0x45, spaced 4320 cycles apart.
4. **Start glitch.** Drive `RX` low for 100 cycles, then high → `BUSY` pulses and drops at the tick-8 sample. No `DATA_VALID` or `FRAMING_ERROR`; `DATA` unchanged.
5. **Framing error and recovery.**
   - Send 0x55 with the stop bit low, then hold `RX` low for 2 more bit periods → one `FRAMING_ERROR` pulse and `DATA` keeps its prior value.
   - Send 0x45 after `RX` returns high → `DATA_VALID` with `DATA`=0x45.
6. **Reset mid-frame.** Assert `RESET` during bit 3 of 0x3C and release while `RX` is low → no strobes during the remainder of the aborted frame. The next complete frame, 0x5A, is received correctly.
